// File: rtl/fft_frame_sequencer.sv
// Frame sequencer: fills frame RAM from the filter, runs the FFT under
// a watchdog, then drains the frame through a valid/ready output.
module fft_frame_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int N_SAMPLES   = 1024,
  parameter int FFT_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              bpf_rst,
  input  logic              bpf_valid,
  input  logic [DATA_W-1:0] bpf_data,
  output logic              fft_rst,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_din,
  output logic [DATA_W-1:0] fft_dout,
  input  logic              fft_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);
  localparam logic [15:0]   WD_LAST = 16'(FFT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_FFT, S_DRAIN_RD, S_DRAIN_OUT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [15:0]       wd_q, wd_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              we_c;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wd_d        = wd_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FILL;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          wd_d     = '0;
          err_d    = 1'b0;
        end
      end
      S_FILL: begin
        if (bpf_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST) state_d = S_FFT;
        end
      end
      S_FFT: begin
        wd_d = wd_q + 16'd1;
        if (fft_done) begin
          state_d = S_DRAIN_RD;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN_RD: state_d = S_DRAIN_OUT;
      S_DRAIN_OUT: begin
        // first cycle captures the RAM word, later cycles wait for ready
        if (!out_valid_q) begin
          out_data_d  = ram_dout;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          rd_cnt_d    = rd_cnt_q + 1'b1;
          out_valid_d = 1'b0;
          state_d     = (rd_cnt_q == LAST) ? S_DONE : S_DRAIN_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_c     = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    unique case (state_q)
      S_FILL: begin
        we_c     = bpf_valid;
        ram_addr = wr_cnt_q[ADDR_W-1:0];
        ram_din  = bpf_data;
      end
      S_FFT: begin
        we_c     = fft_we;
        ram_addr = fft_addr;
        ram_din  = fft_din;
      end
      S_DRAIN_RD, S_DRAIN_OUT: ram_addr = rd_cnt_q[ADDR_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ram_we    = we_c & ~rst;
  assign fft_dout  = ram_dout;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign bpf_rst   = (state_q != S_FILL);
  assign fft_rst   = (state_q != S_FFT);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: frame RAM and FFT models, scoreboard
// of expected drained words, table-driven normal frame plus corner runs.
module tb_fft_frame_sequencer;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int TO = 20;

  logic          clk = 0;
  logic          rst, start, busy, done, err;
  logic          bpf_rst, bpf_valid, fft_rst, fft_we, fft_done;
  logic [DW-1:0] bpf_data, fft_din, fft_dout, ram_din, ram_dout;
  logic [DW-1:0] out_data;
  logic [AW-1:0] fft_addr, ram_addr;
  logic          ram_we, out_valid, out_ready;

  fft_frame_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .N_SAMPLES(N), .FFT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .err(err), .bpf_rst(bpf_rst), .bpf_valid(bpf_valid),
    .bpf_data(bpf_data), .fft_rst(fft_rst), .fft_we(fft_we),
    .fft_addr(fft_addr), .fft_din(fft_din), .fft_dout(fft_dout),
    .fft_done(fft_done), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_vec = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] din;
    int            gap;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[N];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, req);
    end
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
    chk1("fill_bpf_rst", bpf_rst, 1'b0);
    chk1("fill_busy", busy, 1'b1);
    chk1("start_clears_err", err, 1'b0);
  endtask

  task automatic fill(input logic [DW-1:0] base, input int n,
                      input bit push, input logic [DW-1:0] add,
                      input bit stray);
    for (int i = 0; i < n; i++) begin
      if (stray) begin
        bpf_valid = 0;
        fft_we = 1;
        fft_addr = AW'(i);
        fft_din = 32'hdead_0000;
        #1 chk1("fill_fft_we_blocked", ram_we, 1'b0);
        @(negedge clk);
        fft_we = 0;
      end
      bpf_valid = 1;
      bpf_data = base + DW'(i);
      #1;
      chk("fill_addr", DW'(ram_addr), DW'(i));
      chk1("fill_we", ram_we, 1'b1);
      if (push) exp_q.push_back(base + DW'(i) + add);
      @(negedge clk);
    end
    bpf_valid = 0;
    if (n == N) chk1("fft_entry_rst", fft_rst, 1'b0);
  endtask

  task automatic fft_run(input bit stray);
    for (int i = 0; i < N; i++) begin
      fft_we = 0;
      fft_addr = AW'(i);
      bpf_valid = stray;
      if (stray) #1 chk1("fft_bpf_blocked", ram_we, 1'b0);
      @(negedge clk);
      bpf_valid = 0;
      fft_we = 1;
      fft_din = fft_dout + 32'h100;
      @(negedge clk);
    end
    fft_we = 0;
    fft_done = 1;
    @(negedge clk);
    fft_done = 0;
  endtask

  task automatic drain(input bit bp, input bit pulse_start,
                       input bit stray, input bit chk_lat);
    int cyc = 1;
    int acc = 0;
    int hold = 0;
    bit seen = 0;
    bit first = 1;
    logic pv = 0;
    logic pr = 0;
    logic [DW-1:0] pd = '0;
    logic [DW-1:0] e;
    while (!seen && cyc < 200) begin
      if (done) begin
        seen = 1;
      end else begin
        if (pv && !pr) begin
          chk1("bp_valid_hold", out_valid, 1'b1);
          chk("bp_data_hold", out_data, pd);
        end
        if (out_valid && first) begin
          if (chk_lat) chk("first_valid_lat", DW'(cyc), 32'd3);
          first = 0;
        end
        if (bp && acc == 3 && out_valid && hold < 5) begin
          out_ready = 0;
          hold++;
        end else begin
          out_ready = 1;
        end
        start = pulse_start && (cyc == 4);
        bpf_valid = stray && (cyc % 2 == 0);
        if (stray) #1 chk1("drain_bpf_blocked", ram_we, 1'b0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("drain_extra", out_data, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("drain_data", out_data, e);
          end
          acc++;
        end
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
        @(negedge clk);
        cyc++;
      end
    end
    start = 0;
    bpf_valid = 0;
    out_ready = 1;
    chk1("drain_done_seen", seen, 1'b1);
    chk("drain_count", DW'(acc), DW'(N));
    if (bp) chk("bp_hold_cycles", DW'(hold), 32'd5);
    chk("sb_empty", DW'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk1("done_one_pulse", done, 1'b0);
    chk1("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    bit dseen;
    rst = 1; start = 0; bpf_valid = 0; bpf_data = '0;
    fft_we = 0; fft_addr = '0; fft_din = '0; fft_done = 0;
    out_ready = 1;
    for (int i = 0; i < N; i++)
      tbl[i] = '{din: 32'h10 + DW'(i), gap: i % 3,
                 exp: 32'h110 + DW'(i)};
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 32'h0);
    chk1("rst_bpf_rst", bpf_rst, 1'b1);
    chk1("rst_fft_rst", fft_rst, 1'b1);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", DW'(ram_addr), 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    rst = 0;
    @(negedge clk);

    // normal frame from the vector table, gaps between samples
    bpf_valid = 1;
    bpf_data = 32'hbad0;
    #1 chk1("idle_bpf_blocked", ram_we, 1'b0);
    @(negedge clk);
    bpf_valid = 0;
    do_start();
    for (int i = 0; i < N; i++) begin
      repeat (tbl[i].gap) begin
        bpf_valid = 0;
        @(negedge clk);
      end
      bpf_valid = 1;
      bpf_data = tbl[i].din;
      exp_q.push_back(tbl[i].exp);
      @(negedge clk);
    end
    bpf_valid = 0;
    chk1("fft_entry_rst", fft_rst, 1'b0);
    fft_run(0);
    drain(0, 0, 0, 1);

    // backpressure on sample 3
    do_start();
    fill(32'h20, N, 1, 32'h100, 0);
    fft_run(0);
    drain(1, 0, 0, 0);

    // isolation of stray strobes
    do_start();
    fill(32'h70, N, 1, 32'h100, 1);
    fft_run(1);
    drain(0, 0, 1, 0);

    // watchdog timeout
    do_start();
    fill(32'h30, N, 0, 32'h0, 0);
    dseen = 0;
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      if (done) dseen = 1;
      if (n == TO - 1) begin
        chk1("to_err_early", err, 1'b0);
        chk1("to_fft_rst_early", fft_rst, 1'b0);
      end
      if (n == TO) begin
        chk1("to_err", err, 1'b1);
        chk1("to_idle", busy, 1'b0);
        chk1("to_fft_rst", fft_rst, 1'b1);
      end
    end
    chk1("to_no_done", dseen, 1'b0);
    do_start();
    fill(32'h40, N, 1, 32'h100, 0);
    fft_run(0);
    drain(0, 0, 0, 0);

    // reset in the middle of a fill
    do_start();
    fill(32'h90, 4, 0, 32'h0, 0);
    rst = 1;
    bpf_valid = 1;
    bpf_data = 32'hbad1;
    #1 chk1("rst_gates_we", ram_we, 1'b0);
    @(negedge clk);
    rst = 0;
    bpf_valid = 0;
    chk1("midrst_idle", busy, 1'b0);
    chk1("midrst_bpf_rst", bpf_rst, 1'b1);
    do_start();
    fill(32'h50, N, 1, 32'h100, 0);
    fft_run(0);
    drain(0, 0, 0, 0);

    // fft_done on the timeout cycle, start during drain
    do_start();
    fill(32'h60, N, 1, 32'h0, 0);
    for (int n = 1; n < TO; n++) @(negedge clk);
    fft_done = 1;
    @(negedge clk);
    fft_done = 0;
    chk1("tie_err", err, 1'b0);
    chk1("tie_busy", busy, 1'b1);
    drain(0, 1, 0, 1);
    chk1("tie_err_end", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
